pc_register: RTL and testbench

- Program-counter register for the single-cycle 32-bit RISC-V core.
- Holds the address of the instruction currently being fetched. Loads the externally computed next PC every clock: sequential, branch or jump.
- Sits between the next-PC mux (upstream) and the instruction memory / PC+4 adder consumers (downstream).
- Also provides convenience outputs: PC+4, previous PC, misalignment flag and a valid flag.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_register.sv | 66 ++++++
 tb/tb_pc_register.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the program-counter register: the
//               default datapath width, the instruction size, the default
//               reset vector, the address type and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

  // An instruction address is misaligned when either of its two low bits is set
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
// Module      : pc_register
// Description : Program-counter register for the single-cycle RV32 core.
//               Loads next_pc on every non-reset rising edge and provides
//               pc+4, the previous pc, a misalignment flag and a valid flag.
//               Optional macro PC_REGISTER_STALL_EN adds a stall input that
//               freezes pc, pc_prev and pc_valid (reset still wins).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_register
  import pc_pkg::*;
#(
  parameter int               XLEN         = pc_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(pc_pkg::DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] next_pc,
`ifdef PC_REGISTER_STALL_EN
  input  logic            stall,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_prev,
  output logic            pc_misaligned,
  output logic            pc_valid
);

  localparam logic [XLEN-1:0] c_step = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_prev;
  logic            r_valid;
  logic            w_load;

`ifdef PC_REGISTER_STALL_EN
  assign w_load = ~stall;
`else
  assign w_load = 1'b1;
`endif

  // PC state: reset to the vector, otherwise capture next_pc and shift old pc
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_VECTOR;
      r_pc_prev <= RESET_VECTOR;
      r_valid   <= 1'b0;
    end else if (w_load) begin
      r_pc      <= next_pc;
      r_pc_prev <= r_pc;
      r_valid   <= 1'b1;
    end
  end

  // Convenience outputs derived purely from the registered pc
  always_comb begin
    pc            = r_pc;
    pc_prev       = r_pc_prev;
    pc_valid      = r_valid;
    pc_plus4      = r_pc + c_step;  // carry out is dropped, so the top address wraps to 0
    pc_misaligned = addr_misaligned(r_pc[1:0]);
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_register
// Description : Self-checking bench for pc_register. Directed scenarios from
//               the test plan plus a randomized run against a history-based
//               reference model of the architectural pc sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_register;

  localparam logic [31:0] c_rv = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
`ifdef PC_REGISTER_STALL_EN
  logic        stall;
`endif
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_prev;
  logic        pc_misaligned;
  logic        pc_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: list of addresses the pc has committed to, newest last
  logic [31:0] hist[$];
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_prev;
  logic [31:0] exp_p4;
  logic        exp_mis;

  pc_register #(
    .XLEN         (32),
    .RESET_VECTOR (c_rv)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .next_pc       (next_pc),
`ifdef PC_REGISTER_STALL_EN
    .stall         (stall),
`endif
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_prev       (pc_prev),
    .pc_misaligned (pc_misaligned),
    .pc_valid      (pc_valid)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, wait past the edge and advance the reference model
  task automatic cycle(input logic [31:0] npc, input logic rst, input logic stl);
    next_pc = npc;
    reset   = rst;
`ifdef PC_REGISTER_STALL_EN
    stall   = stl;
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      hist = {c_rv, c_rv};
      exp_valid = 1'b0;
    end else if (!stl) begin
      hist.push_back(npc);
      exp_valid = 1'b1;
    end
    if (hist.size() > 4) void'(hist.pop_front());
    exp_pc   = hist[hist.size()-1];
    exp_prev = hist[hist.size()-2];
    exp_p4   = 32'((64'(exp_pc) + 64'd4) % 64'h1_0000_0000);
    exp_mis  = (exp_pc % 4) != 0;
  endtask

  task automatic test_reset();
    cycle(32'h0, 1'b1, 1'b0);
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    n_cmp++; if (pc_prev !== 32'h0) begin n_err++; $display("FAIL reset_prev got %h want %h", pc_prev, 32'h0); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", pc_valid); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_plus4 got %h want %h", pc_plus4, 32'h4); end
  endtask

  task automatic test_sequential();
    logic [31:0] vals[3];
    logic [31:0] prevs[3];
    vals  = '{32'd4, 32'd8, 32'd100};
    prevs = '{32'd0, 32'd4, 32'd8};
    for (int i = 0; i < 3; i++) begin
      cycle(vals[i], 1'b0, 1'b0);
      n_cmp++; if (pc !== vals[i]) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, vals[i]); end
      n_cmp++; if (pc_prev !== prevs[i]) begin n_err++; $display("FAIL seq_prev[%0d] got %h want %h", i, pc_prev, prevs[i]); end
      n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got %b want 1", i, pc_valid); end
    end
  endtask

  task automatic test_wrap();
    cycle(32'hFFFF_FFFC, 1'b0, 1'b0);
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h want %h", pc, 32'hFFFF_FFFC); end
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got %h want %h", pc_plus4, 32'h0); end
    n_cmp++; if (pc_misaligned !== 1'b0) begin n_err++; $display("FAIL wrap_mis got %b want 0", pc_misaligned); end
  endtask

  task automatic test_misaligned();
    cycle(32'h0000_0102, 1'b0, 1'b0);
    n_cmp++; if (pc !== 32'h102) begin n_err++; $display("FAIL mis_pc got %h want %h", pc, 32'h102); end
    n_cmp++; if (pc_misaligned !== 1'b1) begin n_err++; $display("FAIL mis_flag got %b want 1", pc_misaligned); end
    n_cmp++; if (pc_plus4 !== 32'h106) begin n_err++; $display("FAIL mis_plus4 got %h want %h", pc_plus4, 32'h106); end
    cycle(32'h0000_0104, 1'b0, 1'b0);
    n_cmp++; if (pc_misaligned !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b want 0", pc_misaligned); end
    cycle(32'h0000_0001, 1'b0, 1'b0);
    n_cmp++; if (pc_misaligned !== 1'b1) begin n_err++; $display("FAIL mis_bit0 got %b want 1", pc_misaligned); end
  endtask

  task automatic test_reset_mid();
    cycle(32'd100, 1'b0, 1'b0);
    cycle(32'd200, 1'b1, 1'b0);
    n_cmp++; if (pc !== c_rv) begin n_err++; $display("FAIL rstmid_pc got %h want %h", pc, c_rv); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", pc_valid); end
    n_cmp++; if (pc_prev !== c_rv) begin n_err++; $display("FAIL rstmid_prev got %h want %h", pc_prev, c_rv); end
    cycle(32'd4, 1'b0, 1'b0);
    n_cmp++; if (pc !== 32'd4) begin n_err++; $display("FAIL rstmid_next_pc got %h want %h", pc, 32'd4); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_next_valid got %b want 1", pc_valid); end
  endtask

  task automatic test_hold();
    cycle(32'h0000_0040, 1'b0, 1'b0);
    cycle(32'h0000_0040, 1'b0, 1'b0);
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL hold_pc got %h want %h", pc, 32'h40); end
    n_cmp++; if (pc_prev !== 32'h40) begin n_err++; $display("FAIL hold_prev got %h want %h", pc_prev, 32'h40); end
  endtask

`ifdef PC_REGISTER_STALL_EN
  task automatic test_stall();
    cycle(32'd4, 1'b0, 1'b0);
    cycle(32'd8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(32'd12, 1'b0, 1'b1);
      n_cmp++; if (pc !== 32'd8) begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc, 32'd8); end
      n_cmp++; if (pc_prev !== 32'd4) begin n_err++; $display("FAIL stall_prev[%0d] got %h want %h", i, pc_prev, 32'd4); end
    end
    cycle(32'd12, 1'b0, 1'b0);
    n_cmp++; if (pc !== 32'd12) begin n_err++; $display("FAIL stall_release got %h want %h", pc, 32'd12); end
    n_cmp++; if (pc_prev !== 32'd8) begin n_err++; $display("FAIL stall_release_prev got %h want %h", pc_prev, 32'd8); end
    cycle(32'd16, 1'b1, 1'b1);
    n_cmp++; if (pc !== c_rv || pc_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_reset_prio got pc=%h valid=%b want pc=%h valid=0", pc, pc_valid, c_rv);
    end
    cycle(32'd20, 1'b0, 1'b1);
    n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid_hold got %b want 0", pc_valid); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] npc;
    logic        rst;
    logic        stl;
    for (int i = 0; i < 300; i++) begin
      npc = $urandom();
      if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) npc = 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 15) == 0);
      stl = 1'b0;
`ifdef PC_REGISTER_STALL_EN
      stl = ($urandom_range(0, 3) == 0);
`endif
      cycle(npc, rst, stl);
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, exp_pc); end
      n_cmp++; if (pc_prev !== exp_prev) begin n_err++; $display("FAIL rnd_prev[%0d] got %h want %h", i, pc_prev, exp_prev); end
      n_cmp++; if (pc_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, pc_valid, exp_valid); end
      n_cmp++; if (pc_plus4 !== exp_p4) begin n_err++; $display("FAIL rnd_plus4[%0d] got %h want %h", i, pc_plus4, exp_p4); end
      n_cmp++; if (pc_misaligned !== exp_mis) begin n_err++; $display("FAIL rnd_mis[%0d] got %b want %b", i, pc_misaligned, exp_mis); end
    end
  endtask

  // Scenario sequence
  initial begin
    reset   = 1'b1;
    next_pc = 32'h0;
`ifdef PC_REGISTER_STALL_EN
    stall   = 1'b0;
`endif
    test_reset();
    test_sequential();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_hold();
`ifdef PC_REGISTER_STALL_EN
    test_stall();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
